// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths and FSM state encoding for the I2C target
package i2c_pkg;
    localparam int I2C_DATA_W = 12;
    localparam int I2C_ADDR_W = 7;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WR_BYTE   = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_RD_BYTE   = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;
    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        ADDR      = S_ADDR,
        ADDR_ACK  = S_ADDR_ACK,
        WR_BYTE   = S_WR_BYTE,
        WR_ACK    = S_WR_ACK,
        RD_BYTE   = S_RD_BYTE,
        RD_ACK    = S_RD_ACK,
        WAIT_STOP = S_WAIT_STOP
    } i2c_slv_state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SCL/SDA synchroniser with optional FILTER_LEN glitch filter (I2C_SLAVE_GLITCH_FILTER_EN), edge/START/STOP detect
module i2c_line_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);
    logic [1:0] r_meta, r_sync, r_prev, w_line;
    if (FILTER_LEN < 2) begin : g_chk
        $error("FILTER_LEN must be at least 2");
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
            r_prev <= '1;
        end else begin
            r_meta <= {i_scl, i_sda};
            r_sync <= r_meta;
            r_prev <= w_line;
        end
    end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0][FILTER_LEN-1:0] r_hist;
    logic [1:0]                 r_filt;
    // a line level is accepted only after FILTER_LEN identical samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '1;
            r_filt <= '1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_hist[i] <= {r_hist[i][FILTER_LEN-2:0], r_sync[i]};
                r_filt[i] <= &r_hist[i] ? 1'b1 : ~|r_hist[i] ? 1'b0 : r_filt[i];
            end
        end
    end
    assign w_line = r_filt;
`else
    assign w_line = r_sync;
`endif
    assign o_sda      = w_line[0];
    assign o_scl_rise = w_line[1] & ~r_prev[1];
    assign o_scl_fall = ~w_line[1] & r_prev[1];
    assign o_start    = w_line[1] & r_prev[1] & r_prev[0] & ~w_line[0];
    assign o_stop     = w_line[1] & r_prev[1] & ~r_prev[0] & w_line[0];
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target moving one 12-bit word per transfer; SCL/SDA glitch filter under I2C_SLAVE_GLITCH_FILTER_EN
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [I2C_ADDR_W-1:0] own_address,
    input  logic [I2C_DATA_W-1:0] data_in,
    output logic [I2C_DATA_W-1:0] data_out,
    output logic                  wr_valid,
    output logic                  rd_req,
    output logic                  busy,
    input  logic                  scl,
    inout  wire                   sda
);
    i2c_slv_state_t        r_state;
    logic [2:0]            r_bit_cnt;
    logic                  r_byte_cnt, r_full, r_rw, r_sda_oe, r_busy, r_wr_valid, r_rd_req;
    logic [7:0]            r_shift, r_byte0;
    logic [I2C_DATA_W-1:0] r_tx, r_data_out;
    logic                  w_rise, w_fall, w_start, w_stop, w_sda;

    i2c_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_scl     (scl),
        .i_sda     (sda),
        .o_scl_rise(w_rise),
        .o_scl_fall(w_fall),
        .o_start   (w_start),
        .o_stop    (w_stop),
        .o_sda     (w_sda)
    );

    assign sda      = r_sda_oe ? 1'b0 : 1'bz;
    assign data_out = r_data_out;
    assign wr_valid = r_wr_valid;
    assign rd_req   = r_rd_req;
    assign busy     = r_busy;

    // r_full marks a complete byte, so the transition waits for the following SCL fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_byte_cnt <= 1'b0;
            r_full     <= 1'b0;
            r_rw       <= 1'b0;
            r_shift    <= '0;
            r_byte0    <= '0;
            r_tx       <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
        end else begin
            r_wr_valid <= 1'b0;
            r_rd_req   <= 1'b0;
            if (w_start) begin
                r_state    <= ADDR;
                r_bit_cnt  <= '0;
                r_byte_cnt <= 1'b0;
                r_full     <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_rise) begin
                if (r_state == ADDR || r_state == WR_BYTE) begin
                    r_shift   <= {r_shift[6:0], w_sda};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_full    <= r_bit_cnt == 3'd7;
                end else if (r_state == RD_ACK) begin
                    if (!w_sda && !r_byte_cnt) r_full <= 1'b1;
                    else r_state <= WAIT_STOP;
                end
            end else if (w_fall) begin
                unique case (r_state)
                    ADDR: if (r_full) begin
                        r_full <= 1'b0;
                        if (r_shift[7:1] == own_address) begin
                            r_state  <= ADDR_ACK;
                            r_sda_oe <= 1'b1;
                            r_busy   <= 1'b1;
                            r_rw     <= r_shift[0];
                            r_rd_req <= r_shift[0];
                            if (r_shift[0]) r_tx <= data_in;
                        end else r_state <= IDLE;
                    end
                    ADDR_ACK: begin
                        r_state   <= r_rw ? RD_BYTE : WR_BYTE;
                        r_sda_oe  <= r_rw & ~r_tx[I2C_DATA_W-1];
                        r_tx      <= {r_tx[I2C_DATA_W-2:0], 1'b0};
                        r_bit_cnt <= {2'b00, r_rw};
                    end
                    WR_BYTE: if (r_full) begin
                        r_state  <= WR_ACK;
                        r_sda_oe <= 1'b1;
                        r_full   <= 1'b0;
                    end
                    WR_ACK: begin
                        r_sda_oe   <= 1'b0;
                        r_byte_cnt <= 1'b1;
                        if (r_byte_cnt) begin
                            r_data_out <= {r_byte0, r_shift[7:4]};
                            r_wr_valid <= 1'b1;
                            r_state    <= WAIT_STOP;
                        end else begin
                            r_byte0 <= r_shift;
                            r_state <= WR_BYTE;
                        end
                    end
                    RD_BYTE: if (r_full) begin
                        r_state  <= RD_ACK;
                        r_sda_oe <= 1'b0;
                        r_full   <= 1'b0;
                    end else begin
                        r_sda_oe  <= ~r_tx[I2C_DATA_W-1];
                        r_tx      <= {r_tx[I2C_DATA_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_full    <= r_bit_cnt == 3'd7;
                    end
                    RD_ACK: if (r_full) begin
                        r_state    <= RD_BYTE;
                        r_byte_cnt <= 1'b1;
                        r_sda_oe   <= ~r_tx[I2C_DATA_W-1];
                        r_tx       <= {r_tx[I2C_DATA_W-2:0], 1'b0};
                        r_bit_cnt  <= 3'd1;
                        r_full     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master bench for i2c_slave (glitch expectations follow I2C_SLAVE_GLITCH_FILTER_EN)
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam int Q = 25;
    logic        clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_oe = 1'b0;
    logic [6:0]  own_address = 7'h50;
    logic [11:0] data_in = 12'h000, data_out;
    logic        wr_valid, rd_req, busy, ack, clash = 1'b0;
    logic [7:0]  b0, b1;
    wire         sda;
    int          n_cmp = 0, n_err = 0, n_wr = 0, n_rd = 0, n_drv = 0, s_wr, s_rd, s_drv;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    i2c_slave dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .own_address(own_address),
        .data_in    (data_in),
        .data_out   (data_out),
        .wr_valid   (wr_valid),
        .rd_req     (rd_req),
        .busy       (busy),
        .scl        (scl),
        .sda        (sda)
    );

    always @(negedge clk) begin
        if (wr_valid) n_wr++;
        if (rd_req) n_rd++;
        if (wr_valid && rd_req) clash = 1'b1;
        if (!m_oe && sda === 1'b0) n_drv++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, input logic g, output logic r);
        m_oe = ~b;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        r = sda;
        if (g) begin
            scl = 1'b0;
            tick(1);
            scl = 1'b1;
        end
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic byte_wr(input logic [7:0] d, input int gbit, output logic a);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(d[i], i == gbit, r);
        bit_io(1'b1, 1'b0, a);
    endtask

    task automatic byte_rd(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, 1'b0, r);
            d[i] = r;
        end
        bit_io(nack, 1'b0, r);
    endtask

    task automatic start_c;
        m_oe = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_oe = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c;
        m_oe = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_oe = 1'b0;
        tick(Q);
    endtask

    initial begin
        logic r;
        tick(5);
        chk("rst_data_out", data_out, 12'h000);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sda", sda, 1'b1);
        rst_n = 1'b1;
        tick(10);

        s_wr = n_wr;
        start_c;
        byte_wr(8'hA0, -1, ack);
        chk("wr_addr_ack", ack, 1'b0);
        chk("wr_busy", busy, 1'b1);
        byte_wr(8'hAB, -1, ack);
        chk("wr_b0_ack", ack, 1'b0);
        byte_wr(8'hC0, -1, ack);
        chk("wr_b1_ack", ack, 1'b0);
        stop_c;
        tick(10);
        chk("wr_data", data_out, 12'hABC);
        chk("wr_pulses", n_wr - s_wr, 1);
        chk("wr_busy_end", busy, 1'b0);

        data_in = 12'h5A3;
        s_rd = n_rd;
        s_wr = n_wr;
        start_c;
        byte_wr(8'hA1, -1, ack);
        chk("rd_addr_ack", ack, 1'b0);
        chk("rd_req_pulses", n_rd - s_rd, 1);
        byte_rd(1'b0, b0);
        byte_rd(1'b1, b1);
        chk("rd_byte0", b0, 8'h5A);
        chk("rd_byte1", b1, 8'h30);
        chk("rd_word", {b0, b1[7:4]}, 12'h5A3);
        chk("rd_release", sda, 1'b1);
        stop_c;
        tick(10);
        chk("rd_no_wr", n_wr - s_wr, 0);

        s_wr = n_wr;
        s_drv = n_drv;
        start_c;
        byte_wr(8'hA2, -1, ack);
        chk("bad_addr_nack", ack, 1'b1);
        chk("bad_addr_busy", busy, 1'b0);
        stop_c;
        tick(10);
        chk("bad_addr_no_drive", n_drv - s_drv, 0);
        chk("bad_addr_no_wr", n_wr - s_wr, 0);

        start_c;
        byte_wr(8'hA0, -1, ack);
        for (int i = 7; i >= 4; i--) bit_io(i == 4, 1'b0, r);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 12'h000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sda", sda, 1'b1);
        chk("mid_rst_wr_valid", wr_valid, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        stop_c;
        tick(10);
        s_wr = n_wr;
        start_c;
        byte_wr(8'hA0, -1, ack);
        chk("post_rst_addr_ack", ack, 1'b0);
        byte_wr(8'h12, -1, ack);
        byte_wr(8'h30, -1, ack);
        chk("post_rst_b1_ack", ack, 1'b0);
        stop_c;
        tick(10);
        chk("post_rst_data", data_out, 12'h123);
        chk("post_rst_pulses", n_wr - s_wr, 1);

        s_wr = n_wr;
        start_c;
        byte_wr(8'hA0, -1, ack);
        byte_wr(8'h77, -1, ack);
        chk("part_b0_ack", ack, 1'b0);
        stop_c;
        tick(10);
        chk("part_no_wr", n_wr - s_wr, 0);
        chk("part_data", data_out, 12'h123);
        chk("part_busy", busy, 1'b0);
        data_in = 12'h9E1;
        s_rd = n_rd;
        start_c;
        byte_wr(8'hA0, -1, ack);
        start_c;
        byte_wr(8'hA1, -1, ack);
        chk("rs_addr_ack", ack, 1'b0);
        byte_rd(1'b0, b0);
        byte_rd(1'b1, b1);
        stop_c;
        tick(10);
        chk("rs_word", {b0, b1}, 16'h9E10);
        chk("rs_rd_req", n_rd - s_rd, 1);

        s_wr = n_wr;
        start_c;
        byte_wr(8'hA0, -1, ack);
        byte_wr(8'h3C, -1, ack);
        byte_wr(8'h50, 0, ack);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        chk("glitch_b1_ack", ack, 1'b0);
`else
        chk("glitch_b1_ack", ack, 1'b1);
`endif
        stop_c;
        tick(10);
        chk("glitch_data", data_out, 12'h3C5);
        chk("glitch_pulses", n_wr - s_wr, 1);
        chk("end_busy", busy, 1'b0);
        chk("wr_rd_clash", clash, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
